flog_trace_buffer: RTL and testbench

- Parametrised successor to the clock-enabled logged flip-flop.
- Holds a WIDTH-bit CE-gated register.
- On each enabled cycle where a log event passes the runtime level threshold, pushes a timestamped record {level, timestamp, O before update, I} into an on-chip FIFO.
- Records drain over a valid/ready port to a trace unloader.
- Overflow is counted and never stalls the datapath.

---
 rtl/flog_trace_buffer.sv | 129 ++++++++++++
 tb/tb_flog_trace_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flog_trace_buffer.sv
// flog_trace_buffer
//   A WIDTH-bit register with a clock enable. Each enabled cycle can also log
//   an event: a timestamped record {level, ts, O before update, I} is pushed
//   into a first-word-fall-through FIFO. The FIFO drains over a valid/ready
//   port. When the FIFO is full, new records are dropped and counted; the
//   datapath never stalls.
//
// Ports
//   CLK         clock, rising edge
//   ASYNCRESET  asynchronous reset, active high
//   I / O       register data in / registered data out
//   CE          clock enable for the register and for logging
//   EVT_VALID   log request this cycle
//   EVT_LEVEL   event level (0 DEBUG .. 3 ERROR)
//   LOG_LEVEL   threshold; an event passes when EVT_LEVEL >= LOG_LEVEL
//   RD_VALID    FIFO head valid
//   RD_READY    consumer accepts the head
//   RD_DATA     head record {level, ts, o_prev, i}, MSB first
//   COUNT       FIFO occupancy
//   DROP_COUNT  saturating count of records dropped while full
//   OVERFLOW    sticky flag, set on the first drop
//   DROP_CLR    synchronous clear of DROP_COUNT and OVERFLOW
module flog_trace_buffer #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    parameter int DROP_W = 16
) (
    input  logic                        CLK,
    input  logic                        ASYNCRESET,
    input  logic [WIDTH-1:0]            I,
    input  logic                        CE,
    output logic [WIDTH-1:0]            O,
    input  logic                        EVT_VALID,
    input  logic [1:0]                  EVT_LEVEL,
    input  logic [1:0]                  LOG_LEVEL,
    output logic                        RD_VALID,
    input  logic                        RD_READY,
    output logic [2+TS_W+2*WIDTH-1:0]   RD_DATA,
    output logic [$clog2(DEPTH):0]      COUNT,
    output logic [DROP_W-1:0]           DROP_COUNT,
    output logic                        OVERFLOW,
    input  logic                        DROP_CLR
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int REC_W = 2 + TS_W + 2 * WIDTH;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [TS_W-1:0]  ts;

    logic full;
    logic pop;
    logic push_req;
    logic push;
    logic drop;

    assign full     = (count == FULL_CNT);
    assign pop      = (count != '0) & RD_READY;
    assign push_req = CE & EVT_VALID & (EVT_LEVEL >= LOG_LEVEL);
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    assign RD_VALID = (count != '0);
    assign RD_DATA  = mem[rd_ptr];
    assign COUNT    = count;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            O  <= '0;
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
            if (CE) begin
                O <= I;
            end
        end
    end

    // Storage needs no reset: RD_DATA is only meaningful while RD_VALID is high.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {EVT_LEVEL, ts, O, I};
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A clear coinciding with a drop leaves exactly that one drop recorded.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            DROP_COUNT <= '0;
            OVERFLOW   <= 1'b0;
        end else if (DROP_CLR) begin
            DROP_COUNT <= drop ? DROP_W'(1) : '0;
            OVERFLOW   <= drop;
        end else if (drop) begin
            if (DROP_COUNT != '1) begin
                DROP_COUNT <= DROP_COUNT + DROP_W'(1);
            end
            OVERFLOW <= 1'b1;
        end
    end

endmodule

// File: tb/tb_flog_trace_buffer.sv
module tb_flog_trace_buffer;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int TS_W   = 8;
    localparam int DROP_W = 4;
    localparam int REC_W  = 2 + TS_W + 2 * WIDTH;

    logic              CLK;
    logic              ASYNCRESET;
    logic [WIDTH-1:0]  I;
    logic              CE;
    logic [WIDTH-1:0]  O;
    logic              EVT_VALID;
    logic [1:0]        EVT_LEVEL;
    logic [1:0]        LOG_LEVEL;
    logic              RD_VALID;
    logic              RD_READY;
    logic [REC_W-1:0]  RD_DATA;
    logic [2:0]        COUNT;
    logic [DROP_W-1:0] DROP_COUNT;
    logic              OVERFLOW;
    logic              DROP_CLR;

    flog_trace_buffer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)
    ) dut (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .I(I), .CE(CE), .O(O),
        .EVT_VALID(EVT_VALID), .EVT_LEVEL(EVT_LEVEL), .LOG_LEVEL(LOG_LEVEL),
        .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA),
        .COUNT(COUNT), .DROP_COUNT(DROP_COUNT), .OVERFLOW(OVERFLOW),
        .DROP_CLR(DROP_CLR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a queue of records plus plain counters.
    logic [REC_W-1:0]  mq[$];
    logic [WIDTH-1:0]  m_o;
    logic [TS_W-1:0]   m_ts;
    int                m_drop;
    logic              m_ovf;

    function automatic logic [REC_W-1:0] rec(input logic [1:0] l, input logic [7:0] t,
                                             input logic [7:0] op, input logic [7:0] ii);
        return {l, t, op, ii};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_o    = '0;
        m_ts   = '0;
        m_drop = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_update();
        int  sz;
        bit  pr, pp, dr;
        sz = mq.size();
        pr = CE && EVT_VALID && (int'(EVT_LEVEL) >= int'(LOG_LEVEL));
        pp = (sz != 0) && RD_READY;
        dr = 1'b0;
        if (pp) void'(mq.pop_front());
        if (pr) begin
            if (sz < DEPTH || pp) mq.push_back(rec(EVT_LEVEL, m_ts, m_o, I));
            else dr = 1'b1;
        end
        if (DROP_CLR) begin
            m_drop = dr ? 1 : 0;
            m_ovf  = dr;
        end else if (dr) begin
            if (m_drop < (1 << DROP_W) - 1) m_drop++;
            m_ovf = 1'b1;
        end
        if (CE) m_o = I;
        m_ts = m_ts + 1'b1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".O"}, O, m_o);
        chk({tag, ".COUNT"}, COUNT, mq.size());
        chk({tag, ".RD_VALID"}, RD_VALID, mq.size() != 0);
        chk({tag, ".DROP_COUNT"}, DROP_COUNT, m_drop);
        chk({tag, ".OVERFLOW"}, OVERFLOW, m_ovf);
        if (mq.size() != 0) chk({tag, ".RD_DATA"}, RD_DATA, mq[0]);
    endtask

    task automatic step();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic drive(input logic ce, input logic [7:0] i, input logic ev,
                         input logic [1:0] el, input logic [1:0] ll,
                         input logic rdy, input logic clr);
        CE = ce; I = i; EVT_VALID = ev; EVT_LEVEL = el; LOG_LEVEL = ll;
        RD_READY = rdy; DROP_CLR = clr;
    endtask

    // Called one time unit after a rising edge: asserts reset between edges.
    task automatic reset_mid(input string tag);
        #2;
        ASYNCRESET = 1'b1;
        model_reset();
        #1;
        chk({tag, ".RD_VALID"}, RD_VALID, 1'b0);
        chk({tag, ".COUNT"}, COUNT, 0);
        chk({tag, ".O"}, O, 0);
        chk({tag, ".DROP_COUNT"}, DROP_COUNT, 0);
        chk({tag, ".OVERFLOW"}, OVERFLOW, 0);
        @(posedge CLK);
        #1;
        ASYNCRESET = 1'b0;
    endtask

    typedef struct {
        logic             ce;
        logic [7:0]       i;
        logic             ev;
        logic [1:0]       el;
        logic [1:0]       ll;
        logic             rdy;
        logic             clr;
        logic [7:0]       o;
        logic [2:0]       cnt;
        logic             vld;
        logic [3:0]       drop;
        logic             ovf;
        logic [REC_W-1:0] data;
    } vec_t;

    function automatic vec_t v(input logic ce, input logic [7:0] i, input logic ev,
                               input logic [1:0] el, input logic [1:0] ll,
                               input logic rdy, input logic clr,
                               input logic [7:0] o, input logic [2:0] cnt,
                               input logic vld, input logic [3:0] drop,
                               input logic ovf, input logic [REC_W-1:0] data);
        vec_t r;
        r.ce = ce; r.i = i; r.ev = ev; r.el = el; r.ll = ll; r.rdy = rdy; r.clr = clr;
        r.o = o; r.cnt = cnt; r.vld = vld; r.drop = drop; r.ovf = ovf; r.data = data;
        return r;
    endfunction

    vec_t tbl[18];

    initial begin
        int guard;
        int thr;

        //           ce  i      ev el ll rdy clr | o      cnt vld drop ovf data
        tbl[0]  = v(1, 8'h5A, 0, 0, 0, 0, 0,  8'h5A, 0, 0, 0, 0, '0);
        tbl[1]  = v(0, 8'hFF, 1, 3, 0, 0, 0,  8'h5A, 0, 0, 0, 0, '0);
        tbl[2]  = v(0, 8'hFF, 0, 0, 0, 0, 0,  8'h5A, 0, 0, 0, 0, '0);
        tbl[3]  = v(1, 8'h11, 1, 0, 1, 0, 0,  8'h11, 0, 0, 0, 0, '0);
        tbl[4]  = v(1, 8'h22, 1, 2, 1, 0, 0,  8'h22, 1, 1, 0, 0, rec(2, 8'h04, 8'h11, 8'h22));
        tbl[5]  = v(0, 8'h00, 0, 0, 1, 1, 0,  8'h22, 0, 0, 0, 0, '0);
        tbl[6]  = v(1, 8'h30, 1, 3, 1, 0, 0,  8'h30, 1, 1, 0, 0, rec(3, 8'h06, 8'h22, 8'h30));
        tbl[7]  = v(1, 8'h31, 1, 3, 1, 0, 0,  8'h31, 2, 1, 0, 0, rec(3, 8'h06, 8'h22, 8'h30));
        tbl[8]  = v(1, 8'h32, 1, 3, 1, 0, 0,  8'h32, 3, 1, 0, 0, rec(3, 8'h06, 8'h22, 8'h30));
        tbl[9]  = v(1, 8'h33, 1, 3, 1, 0, 0,  8'h33, 4, 1, 0, 0, rec(3, 8'h06, 8'h22, 8'h30));
        tbl[10] = v(1, 8'h34, 1, 3, 1, 0, 0,  8'h34, 4, 1, 1, 1, rec(3, 8'h06, 8'h22, 8'h30));
        tbl[11] = v(1, 8'h35, 1, 3, 1, 0, 0,  8'h35, 4, 1, 2, 1, rec(3, 8'h06, 8'h22, 8'h30));
        tbl[12] = v(1, 8'h40, 1, 1, 1, 1, 0,  8'h40, 4, 1, 2, 1, rec(3, 8'h07, 8'h30, 8'h31));
        tbl[13] = v(1, 8'h41, 1, 1, 1, 0, 1,  8'h41, 4, 1, 1, 1, rec(3, 8'h07, 8'h30, 8'h31));
        tbl[14] = v(0, 8'h00, 0, 0, 1, 1, 0,  8'h41, 3, 1, 1, 1, rec(3, 8'h08, 8'h31, 8'h32));
        tbl[15] = v(0, 8'h00, 0, 0, 1, 1, 0,  8'h41, 2, 1, 1, 1, rec(3, 8'h09, 8'h32, 8'h33));
        tbl[16] = v(0, 8'h00, 0, 0, 1, 1, 0,  8'h41, 1, 1, 1, 1, rec(1, 8'h0C, 8'h35, 8'h40));
        tbl[17] = v(0, 8'h00, 0, 0, 1, 1, 0,  8'h41, 0, 0, 1, 1, '0);

        ASYNCRESET = 1'b1;
        drive(0, 8'h00, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        chk("reset.O", O, 0);
        chk("reset.COUNT", COUNT, 0);
        chk("reset.RD_VALID", RD_VALID, 0);
        chk("reset.DROP_COUNT", DROP_COUNT, 0);
        chk("reset.OVERFLOW", OVERFLOW, 0);
        @(posedge CLK);
        #1;
        ASYNCRESET = 1'b0;

        for (int k = 0; k < 18; k++) begin
            drive(tbl[k].ce, tbl[k].i, tbl[k].ev, tbl[k].el, tbl[k].ll, tbl[k].rdy, tbl[k].clr);
            step();
            chk($sformatf("vec%0d.O", k), O, tbl[k].o);
            chk($sformatf("vec%0d.COUNT", k), COUNT, tbl[k].cnt);
            chk($sformatf("vec%0d.RD_VALID", k), RD_VALID, tbl[k].vld);
            chk($sformatf("vec%0d.DROP_COUNT", k), DROP_COUNT, tbl[k].drop);
            chk($sformatf("vec%0d.OVERFLOW", k), OVERFLOW, tbl[k].ovf);
            if (tbl[k].vld) chk($sformatf("vec%0d.RD_DATA", k), RD_DATA, tbl[k].data);
        end

        // Timestamp wrap: records at ts=0xFF and ts=0x00 must queue in order.
        drive(0, 8'h00, 0, 0, 0, 1, 0);
        guard = 0;
        while (m_ts != 8'hFF && guard < 300) begin
            step();
            guard++;
        end
        chk("wrap.wait_bound", guard < 300, 1'b1);
        drive(1, 8'hA0, 1, 3, 0, 0, 0);
        step();
        check_model("wrap.p0");
        drive(1, 8'hA1, 1, 3, 0, 0, 0);
        step();
        check_model("wrap.p1");
        chk("wrap.head_ts_ff", RD_DATA[23:16], 8'hFF);
        drive(0, 8'h00, 0, 0, 0, 1, 0);
        step();
        check_model("wrap.pop");
        chk("wrap.head_ts_00", RD_DATA[23:16], 8'h00);
        drive(1, 8'hA2, 1, 2, 0, 0, 0);
        step();
        drive(1, 8'hA3, 1, 2, 0, 0, 0);
        step();
        check_model("wrap.fill");
        chk("wrap.count3", COUNT, 3);
        reset_mid("midreset");
        check_model("after_reset");

        // Random traffic; the ready probability varies per block so the FIFO
        // spends time both full (exercising drop saturation) and draining.
        for (int b = 0; b < 10; b++) begin
            thr = $urandom_range(0, 4);
            for (int c = 0; c < 200; c++) begin
                drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) < 7,
                      2'($urandom), 2'($urandom), $urandom_range(0, 3) < thr,
                      $urandom_range(0, 29) == 0);
                step();
                check_model($sformatf("rnd%0d_%0d", b, c));
            end
            if (b == 5) begin
                reset_mid("rnd_reset");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
